// File: rtl/proc_pkg.sv
// proc_pkg: processor-wide types, widths and opcode constants shared by fetch, Ctrl and TopLevel
package proc_pkg;
   localparam int INST_W = 9;
   localparam int PC_W   = 10;
   typedef logic [INST_W-1:0] inst_t;
   typedef logic [PC_W-1:0]   pc_t;
   localparam logic [2:0] OP_LOAD  = 3'b100;
   localparam logic [2:0] OP_STORE = 3'b101;
   localparam logic [2:0] OP_HALT  = 3'b111;
   function automatic logic [2:0] opcode(input inst_t i_inst);
      return i_inst[INST_W-1:INST_W-3];
   endfunction
endpackage

// File: rtl/inst_fifo.sv
// inst_fifo: circular instruction buffer with flush; head word is forced to zero when empty
module inst_fifo #(
   parameter int W     = 19,
   parameter int DEPTH = 2
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [W-1:0]             i_data,
   output logic [W-1:0]             o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr, r_rd;
   logic [PW:0]   r_count;
   logic          w_do_pop;
   assign o_count  = r_count;
   assign o_full   = r_count == FULL_CNT;
   assign o_empty  = r_count == '0;
   assign w_do_pop = i_pop && !o_empty;
   assign o_data   = o_empty ? '0 : r_mem[r_rd];
   // storage array; the caller never pushes into a full buffer without popping
   always_ff @(posedge i_clk)
      if (i_push) r_mem[r_wr] <= i_data;
   // pointers and occupancy; flush overrides any push or pop in the same cycle
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (w_do_pop) r_rd <= r_rd + 1'b1;
         r_count <= r_count + (PW+1)'(i_push) - (PW+1)'(w_do_pop);
      end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner and InstROM driver feeding decode through a small FIFO, with redirect and halt
module inst_fetch import proc_pkg::*; #(
   parameter int            IW       = INST_W,
   parameter int            AW       = PC_W,
   parameter int            DEPTH    = 2,
   parameter logic [AW-1:0] RESET_PC = '0
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   output logic [AW-1:0] o_rom_addr,
   output logic          o_rom_rd,
   input  logic [IW-1:0] i_rom_data,
   output logic          o_inst_valid,
   input  logic          i_inst_ready,
   output logic [IW-1:0] o_inst,
   output logic [AW-1:0] o_inst_pc,
   input  logic          i_redir_en,
   input  logic [AW-1:0] i_redir_pc,
   input  logic          i_halt_req,
   output logic          o_halted
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_CNT = (CW+1)'(DEPTH);
   logic [AW-1:0]    r_pc, r_rd_pc;
   logic             r_epoch, r_rd_epoch, r_inflight, r_halt_seen;
   logic             w_redir, w_issue, w_push, w_pop, w_full, w_empty;
   logic [CW-1:0]    w_count;
   logic [CW:0]      w_used, w_limit;
   logic [AW+IW-1:0] w_head;
   // issue/return decisions; a pop this cycle frees a slot so streaming sustains one fetch per cycle
   always_comb begin
      w_redir = i_redir_en && !r_halt_seen && !i_halt_req;
      w_pop   = !w_empty && i_inst_ready;
      w_used  = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
      w_limit = DEPTH_CNT + {{CW{1'b0}}, w_pop};
      w_issue = i_rst_n && !r_halt_seen && !i_redir_en && (w_used < w_limit);
      w_push  = r_inflight && (r_rd_epoch == r_epoch) && (!w_full || w_pop);
   end
   // pc, epoch and in-flight read tracking; halt is sticky until reset
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_pc        <= RESET_PC;
         r_rd_pc     <= '0;
         r_epoch     <= 1'b0;
         r_rd_epoch  <= 1'b0;
         r_inflight  <= 1'b0;
         r_halt_seen <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_rd_pc    <= r_pc;
            r_rd_epoch <= r_epoch;
         end
         if (w_redir) begin
            r_pc    <= i_redir_pc;
            r_epoch <= !r_epoch;
         end else if (w_issue) r_pc <= r_pc + 1'b1;
         if (i_halt_req) r_halt_seen <= 1'b1;
      end
   inst_fifo #(.W(AW+IW), .DEPTH(DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_redir),
      .i_data  ({r_rd_pc, i_rom_data}),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );
   assign o_rom_addr   = r_pc;
   assign o_rom_rd     = w_issue;
   assign o_inst_valid = !w_empty;
   assign {o_inst_pc, o_inst} = w_head;
   assign o_halted     = r_halt_seen && !r_inflight;
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a program-order fetch model
module tb_inst_fetch;
   localparam int AW = 10;
   localparam int IW = 9;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] rom_addr;
   logic          rom_rd;
   logic [IW-1:0] rom_data = '0;
   logic          inst_valid;
   logic          ready = 1'b0;
   logic [IW-1:0] inst;
   logic [AW-1:0] inst_pc;
   logic          redir = 1'b0;
   logic [AW-1:0] redir_pc = '0;
   logic          halt = 1'b0;
   logic          halted;
   logic [IW-1:0] rom [1024];
   logic [AW-1:0] exp_pc;
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   // synchronous InstROM: data for the address strobed this cycle appears next cycle
   always @(posedge clk) if (rom_rd) rom_data <= rom[rom_addr];

   inst_fetch dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .o_rom_addr   (rom_addr),
      .o_rom_rd     (rom_rd),
      .i_rom_data   (rom_data),
      .o_inst_valid (inst_valid),
      .i_inst_ready (ready),
      .o_inst       (inst),
      .o_inst_pc    (inst_pc),
      .i_redir_en   (redir),
      .i_redir_pc   (redir_pc),
      .i_halt_req   (halt),
      .o_halted     (halted)
   );

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; ready = 1'b0; redir = 1'b0; halt = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ready = 1'b1; redir = 1'b1; redir_pc = 10'h155; halt = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
      n_cmp++; if (rom_rd !== 1'b0) begin n_err++; $display("FAIL reset_rom_rd: got %b want 0", rom_rd); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
      n_cmp++; if (rom_addr !== 10'h000) begin n_err++; $display("FAIL reset_rom_addr: got %h want 000", rom_addr); end
      n_cmp++; if (inst !== 9'h000) begin n_err++; $display("FAIL reset_inst: got %h want 000", inst); end
      n_cmp++; if (inst_pc !== 10'h000) begin n_err++; $display("FAIL reset_inst_pc: got %h want 000", inst_pc); end
      redir = 1'b0;
   endtask

   task automatic test_stream();
      for (int i = 0; i < 1024; i++) rom[i] = IW'(i);
      do_reset();
      ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk); #1;
         n_cmp++; if (rom_rd !== 1'b1) begin n_err++; $display("FAIL stream_rom_rd k=%0d: got %b want 1", k, rom_rd); end
         if (k == 0) begin
            n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL stream_first_valid: got %b want 0", inst_valid); end
         end else begin
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== AW'(k-1) || inst !== rom[k-1])
               begin n_err++; $display("FAIL stream k=%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, inst_valid, inst_pc, inst, AW'(k-1), rom[k-1]); end
         end
      end
      exp_pc = 10'd19;
   endtask

   task automatic test_backpressure();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); ready = 1'b0; #1;
         n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc)
            begin n_err++; $display("FAIL bp_hold k=%0d: got v=%b pc=%h want v=1 pc=%h", k, inst_valid, inst_pc, exp_pc); end
         if (k >= 1) begin
            n_cmp++; if (rom_rd !== 1'b0) begin n_err++; $display("FAIL bp_rom_rd k=%0d: got %b want 0", k, rom_rd); end
         end
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); ready = 1'b1; #1;
         n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== rom[exp_pc])
            begin n_err++; $display("FAIL bp_resume k=%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, inst_valid, inst_pc, inst, exp_pc, rom[exp_pc]); end
         exp_pc = exp_pc + 1'b1;
      end
   endtask

   task automatic test_redirect(input logic [AW-1:0] target);
      @(negedge clk); ready = 1'b1; redir = 1'b1; redir_pc = target; #1;
      n_cmp++; if (rom_rd !== 1'b0) begin n_err++; $display("FAIL redir_rom_rd: got %b want 0", rom_rd); end
      @(negedge clk); redir = 1'b0; #1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble1: got %b want 0", inst_valid); end
      @(negedge clk); #1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL redir_bubble2: got %b want 0", inst_valid); end
      exp_pc = target;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== rom[exp_pc])
            begin n_err++; $display("FAIL redir_target k=%0d: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h", k, inst_valid, inst_pc, inst, exp_pc, rom[exp_pc]); end
         exp_pc = exp_pc + 1'b1;
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk); ready = 1'b1; #2;
      rst_n = 1'b0; #1;
      n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL areset_valid: got %b want 0", inst_valid); end
      n_cmp++; if (rom_rd !== 1'b0) begin n_err++; $display("FAIL areset_rom_rd: got %b want 0", rom_rd); end
      n_cmp++; if (rom_addr !== 10'h000) begin n_err++; $display("FAIL areset_rom_addr: got %h want 000", rom_addr); end
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         if (k == 0) begin
            n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL areset_restart_first: got %b want 0", inst_valid); end
         end else begin
            n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== AW'(k-1) || inst !== rom[k-1])
               begin n_err++; $display("FAIL areset_restart k=%0d: got v=%b pc=%h want v=1 pc=%h", k, inst_valid, inst_pc, AW'(k-1)); end
         end
      end
   endtask

   task automatic test_halt();
      do_reset();
      @(negedge clk); redir = 1'b1; redir_pc = 10'h003; ready = 1'b0;
      @(negedge clk); redir = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 10'h003) begin n_err++; $display("FAIL halt_setup_head: got v=%b pc=%h want v=1 pc=003", inst_valid, inst_pc); end
      n_cmp++; if (rom_addr !== 10'h005 || rom_rd !== 1'b0) begin n_err++; $display("FAIL halt_setup_pc: got addr=%h rd=%b want addr=005 rd=0", rom_addr, rom_rd); end
      @(negedge clk); halt = 1'b1; #1;
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_early: got %b want 0", halted); end
      @(negedge clk); halt = 1'b0; #1;
      n_cmp++; if (halted !== 1'b1 || rom_rd !== 1'b0) begin n_err++; $display("FAIL halt_set: got halted=%b rd=%b want 1 0", halted, rom_rd); end
      @(negedge clk); ready = 1'b1; redir = 1'b1; redir_pc = 10'h100; #1;
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 10'h003 || inst !== rom[3]) begin n_err++; $display("FAIL halt_drain0: got v=%b pc=%h want v=1 pc=003", inst_valid, inst_pc); end
      @(negedge clk); #1;
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 10'h004 || inst !== rom[4]) begin n_err++; $display("FAIL halt_drain1: got v=%b pc=%h want v=1 pc=004", inst_valid, inst_pc); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         n_cmp++; if (inst_valid !== 1'b0 || rom_rd !== 1'b0 || halted !== 1'b1 || rom_addr !== 10'h005)
            begin n_err++; $display("FAIL halt_idle k=%0d: got v=%b rd=%b halted=%b addr=%h want 0 0 1 005", k, inst_valid, rom_rd, halted, rom_addr); end
      end
      redir = 1'b0;
   endtask

   task automatic test_random();
      int   acc = 0;
      logic prev_redir = 1'b0;
      for (int i = 0; i < 1024; i++) rom[i] = IW'($urandom);
      do_reset();
      exp_pc = '0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         ready    = ($urandom_range(0, 3) != 0);
         redir    = ($urandom_range(0, 11) == 0);
         redir_pc = AW'($urandom);
         #1;
         if (inst_valid) begin
            n_cmp++; if (inst_pc !== exp_pc || inst !== rom[exp_pc])
               begin n_err++; $display("FAIL rand_head c=%0d: got pc=%h inst=%h want pc=%h inst=%h", c, inst_pc, inst, exp_pc, rom[exp_pc]); end
         end
         if (prev_redir) begin
            n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rand_post_redir c=%0d: got %b want 0", c, inst_valid); end
         end
         if (redir) begin
            n_cmp++; if (rom_rd !== 1'b0) begin n_err++; $display("FAIL rand_redir_rd c=%0d: got %b want 0", c, rom_rd); end
         end
         if (redir) exp_pc = redir_pc;
         else if (inst_valid && ready) begin
            exp_pc = exp_pc + 1'b1;
            acc++;
         end
         prev_redir = redir;
      end
      redir = 1'b0;
      n_cmp++; if (acc < 60) begin n_err++; $display("FAIL rand_progress: got %0d accepted want >= 60", acc); end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = '0;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect(10'h3F0);
      test_redirect(10'h3FF);
      test_async_reset();
      test_halt();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
